stage_info_pipe: RTL and testbench

- Sequential producer of the per-stage hazard bookkeeping that the hazard/forwarding unit consumes: Tnew, destination register (A3) and RegWrite for the E, M and W stages.
- Captures decode-stage info each cycle and inserts a bubble into E when Stall or Flush is asserted.
- Decrements Tnew as each instruction advances E→M→W.
- Sits between the controller/decoder in D and the hazard unit, alongside the D/E, E/M and M/W pipeline registers.

---
 rtl/stage_info_pkg.sv | 26 ++
 rtl/stage_info_pipe_slot.sv | 40 ++++
 rtl/stage_info_pipe.sv | 112 +++++++++++
 tb/tb_stage_info_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stage_info_pkg.sv
// Shared types and helpers for the per-stage hazard bookkeeping pipe.
// A stage slot carries {destination register, write flag, remaining latency}.
package stage_info_pkg;

   localparam int unsigned SI_ADDR_W = 5;
   localparam int unsigned SI_TNEW_W = 2;

   // Tnew encodings produced by the decoder in D
   localparam logic [SI_TNEW_W-1:0] TNEW_PC8  = 2'd0;
   localparam logic [SI_TNEW_W-1:0] TNEW_ALU  = 2'd1;
   localparam logic [SI_TNEW_W-1:0] TNEW_LOAD = 2'd2;

   typedef struct packed {
      logic [SI_ADDR_W-1:0] a3;
      logic                 reg_write;
      logic [SI_TNEW_W-1:0] tnew;
   } stage_slot_t;

   localparam stage_slot_t SLOT_BUBBLE = '{a3: '0, reg_write: 1'b0, tnew: '0};

   // Decrement that sticks at zero instead of wrapping to the max value
   function automatic logic [SI_TNEW_W-1:0] sat0_dec(input logic [SI_TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/stage_info_pipe_slot.sv
// One pipeline slot register (stage_slot_reg). Holds when en_i=0, loads a
// bubble when clr_i=1, otherwise captures slot_i, optionally aging Tnew.
import stage_info_pkg::*;

module stage_slot_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic        dec_i,
   input  stage_slot_t slot_i,
   output stage_slot_t slot_o
);

   stage_slot_t slot_q;
   stage_slot_t slot_d;

   // Next slot value: bubble on clear, else the incoming slot with aged Tnew
   always_comb begin
      slot_d = slot_i;
      if (dec_i) begin
         slot_d.tnew = sat0_dec(slot_i.tnew);
      end
      if (clr_i) begin
         slot_d = SLOT_BUBBLE;
      end
   end

   // Slot register; en_i low freezes it regardless of clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= SLOT_BUBBLE;
      end else if (en_i) begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/stage_info_pipe.sv
// Per-stage hazard bookkeeping (Tnew, A3, RegWrite) for the E, M and W stages.
// Optional stall-cycle statistics counter enabled by STAGE_INFO_STATS_EN.
// ADDR_W/TNEW_W must match the widths of stage_info_pkg::stage_slot_t.
import stage_info_pkg::*;

module stage_info_pipe #(
   parameter int unsigned ADDR_W = SI_ADDR_W,
   parameter int unsigned TNEW_W = SI_TNEW_W,
   parameter int unsigned STAT_W = 32
) (
`ifdef STAGE_INFO_STATS_EN
   output logic [STAT_W-1:0] StallCnt,
`endif
   input  logic              clk,
   input  logic              rst_n,
   input  logic              En,
   input  logic              Stall,
   input  logic              Flush,
   input  logic [ADDR_W-1:0] A3_D,
   input  logic              RegWrite_D,
   input  logic [TNEW_W-1:0] Tnew_D,
   output logic [ADDR_W-1:0] A3_E,
   output logic [ADDR_W-1:0] A3_M,
   output logic [ADDR_W-1:0] A3_W,
   output logic              RegWrite_E,
   output logic              RegWrite_M,
   output logic              RegWrite_W,
   output logic [TNEW_W-1:0] Tnew_E,
   output logic [TNEW_W-1:0] Tnew_M,
   output logic [TNEW_W-1:0] Tnew_W
);

   stage_slot_t slot_d_in;
   stage_slot_t slot_e;
   stage_slot_t slot_m;
   stage_slot_t slot_w;
   logic        bubble_e;

   // Decode-stage slot; writes to $0 are never tracked as hazards
   always_comb begin
      slot_d_in.a3        = A3_D;
      slot_d_in.reg_write = RegWrite_D & (A3_D != '0);
      slot_d_in.tnew      = Tnew_D;
   end

   assign bubble_e = Stall | Flush;

   stage_slot_reg u_slot_e (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (En),
      .clr_i  (bubble_e),
      .dec_i  (1'b0),
      .slot_i (slot_d_in),
      .slot_o (slot_e)
   );

   stage_slot_reg u_slot_m (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (En),
      .clr_i  (1'b0),
      .dec_i  (1'b1),
      .slot_i (slot_e),
      .slot_o (slot_m)
   );

   stage_slot_reg u_slot_w (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (En),
      .clr_i  (1'b0),
      .dec_i  (1'b1),
      .slot_i (slot_m),
      .slot_o (slot_w)
   );

   assign A3_E       = slot_e.a3;
   assign RegWrite_E = slot_e.reg_write;
   assign Tnew_E     = slot_e.tnew;
   assign A3_M       = slot_m.a3;
   assign RegWrite_M = slot_m.reg_write;
   assign Tnew_M     = slot_m.tnew;
   assign A3_W       = slot_w.a3;
   assign RegWrite_W = slot_w.reg_write;
   assign Tnew_W     = slot_w.tnew;

`ifdef STAGE_INFO_STATS_EN
   logic [STAT_W-1:0] stall_cnt_q;
   logic [STAT_W-1:0] stall_cnt_d;

   // Saturating count of advancing stall edges; flushes are not counted
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (En && Stall && (stall_cnt_q != {STAT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stage_info_pipe.sv
// Directed self-checking bench for stage_info_pipe. With STAGE_INFO_STATS_EN
// defined, the DUT is built with a 4-bit stall counter to reach saturation.
module tb_stage_info_pipe;

`ifdef STAGE_INFO_STATS_EN
   localparam int unsigned STAT_W = 4;
`else
   localparam int unsigned STAT_W = 32;
`endif

   logic       clk;
   logic       rst_n;
   logic       En;
   logic       Stall;
   logic       Flush;
   logic [4:0] A3_D;
   logic       RegWrite_D;
   logic [1:0] Tnew_D;
   logic [4:0] A3_E, A3_M, A3_W;
   logic       RegWrite_E, RegWrite_M, RegWrite_W;
   logic [1:0] Tnew_E, Tnew_M, Tnew_W;
`ifdef STAGE_INFO_STATS_EN
   logic [STAT_W-1:0] StallCnt;
`endif

   int checks = 0;
   int errors = 0;

   stage_info_pipe #(.ADDR_W(5), .TNEW_W(2), .STAT_W(STAT_W)) dut (
`ifdef STAGE_INFO_STATS_EN
      .StallCnt   (StallCnt),
`endif
      .clk        (clk),
      .rst_n      (rst_n),
      .En         (En),
      .Stall      (Stall),
      .Flush      (Flush),
      .A3_D       (A3_D),
      .RegWrite_D (RegWrite_D),
      .Tnew_D     (Tnew_D),
      .A3_E       (A3_E),
      .A3_M       (A3_M),
      .A3_W       (A3_W),
      .RegWrite_E (RegWrite_E),
      .RegWrite_M (RegWrite_M),
      .RegWrite_W (RegWrite_W),
      .Tnew_E     (Tnew_E),
      .Tnew_M     (Tnew_M),
      .Tnew_W     (Tnew_W)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_slots(input string tag,
                            input logic [4:0] ea, input logic ew, input logic [1:0] et,
                            input logic [4:0] ma, input logic mw, input logic [1:0] mt,
                            input logic [4:0] wa, input logic ww, input logic [1:0] wt);
      chk({tag, ".A3_E"}, 32'(A3_E), 32'(ea));
      chk({tag, ".RW_E"}, 32'(RegWrite_E), 32'(ew));
      chk({tag, ".Tn_E"}, 32'(Tnew_E), 32'(et));
      chk({tag, ".A3_M"}, 32'(A3_M), 32'(ma));
      chk({tag, ".RW_M"}, 32'(RegWrite_M), 32'(mw));
      chk({tag, ".Tn_M"}, 32'(Tnew_M), 32'(mt));
      chk({tag, ".A3_W"}, 32'(A3_W), 32'(wa));
      chk({tag, ".RW_W"}, 32'(RegWrite_W), 32'(ww));
      chk({tag, ".Tn_W"}, 32'(Tnew_W), 32'(wt));
   endtask

   task automatic chk_cnt(input string tag, input int exp);
`ifdef STAGE_INFO_STATS_EN
      chk(tag, 32'(StallCnt), 32'(exp));
`endif
   endtask

   task automatic set_d(input logic [4:0] a, input logic w, input logic [1:0] t);
      A3_D       = a;
      RegWrite_D = w;
      Tnew_D     = t;
   endtask

   // One rising edge, then settle 1 time unit past it before checking
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      En    = 1'b1;
      Stall = 1'b0;
      Flush = 1'b0;
      set_d(5'd0, 1'b0, 2'd0);

      #2 rst_n = 1'b0;
      #1;
      chk_slots("reset", 0,0,0, 0,0,0, 0,0,0);
      chk_cnt("reset.cnt", 0);
      @(negedge clk);
      rst_n = 1'b1;

      // load to $8 walks through E, M, W with Tnew 2,1,0
      set_d(5'd8, 1'b1, 2'd2); step();
      chk_slots("load1", 8,1,2, 0,0,0, 0,0,0);
      set_d(5'd0, 1'b0, 2'd0); step();
      chk_slots("load2", 0,0,0, 8,1,1, 0,0,0);
      step();
      chk_slots("load3", 0,0,0, 0,0,0, 8,1,0);

      // single stall: bubble into E, load advances into M
      set_d(5'd8, 1'b1, 2'd2); step();
      chk_slots("stall0", 8,1,2, 0,0,0, 0,0,0);
      Stall = 1'b1; step();
      chk_slots("stall1", 0,0,0, 8,1,1, 0,0,0);
      chk_cnt("stall1.cnt", 1);
      Stall = 1'b0;

      // write to $0 is not tracked
      set_d(5'd0, 1'b1, 2'd1); step();
      chk_slots("zero1", 0,0,1, 0,0,0, 8,1,0);
      set_d(5'd0, 1'b0, 2'd0); step();
      chk_slots("zero2", 0,0,0, 0,0,0, 0,0,0);
      step();
      chk_slots("zero3", 0,0,0, 0,0,0, 0,0,0);

      // populate, then freeze with Stall and Flush asserted
      set_d(5'd9, 1'b1, 2'd1); step();
      set_d(5'd5, 1'b1, 2'd3); step();
      chk_slots("frz0", 5,1,3, 9,1,0, 0,0,0);
      set_d(5'd7, 1'b1, 2'd2);
      En = 1'b0; Stall = 1'b1; Flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_slots("frz", 5,1,3, 9,1,0, 0,0,0);
         chk_cnt("frz.cnt", 1);
      end
      En = 1'b1; Stall = 1'b0; Flush = 1'b0; step();
      chk_slots("resume", 7,1,2, 5,1,2, 9,1,0);

      // flush alone (not counted), then flush+stall (one bubble, counted)
      Flush = 1'b1; step();
      chk_slots("flush", 0,0,0, 7,1,1, 5,1,1);
      chk_cnt("flush.cnt", 1);
      Stall = 1'b1; step();
      chk_slots("flst", 0,0,0, 0,0,0, 7,1,0);
      chk_cnt("flst.cnt", 2);
      Stall = 1'b0; Flush = 1'b0;

      // jal to $31 with Tnew 0 never wraps
      set_d(5'd31, 1'b1, 2'd0); step();
      chk_slots("jal1", 31,1,0, 0,0,0, 0,0,0);
      set_d(5'd0, 1'b0, 2'd0); step();
      chk_slots("jal2", 0,0,0, 31,1,0, 0,0,0);
      step();
      chk_slots("jal3", 0,0,0, 0,0,0, 31,1,0);

      // Tnew 3 ages 3,2,1
      set_d(5'd3, 1'b1, 2'd3); step();
      set_d(5'd0, 1'b0, 2'd0); step();
      step();
      chk_slots("tn3", 0,0,0, 0,0,0, 3,1,1);

      // held stall: consecutive bubbles while older work drains
      set_d(5'd4, 1'b1, 2'd2); step();
      set_d(5'd6, 1'b1, 2'd1); Stall = 1'b1; step();
      chk_slots("mst1", 0,0,0, 4,1,1, 0,0,0);
      step();
      chk_slots("mst2", 0,0,0, 0,0,0, 4,1,0);
      step();
      chk_slots("mst3", 0,0,0, 0,0,0, 0,0,0);
      chk_cnt("mst.cnt", 5);
      Stall = 1'b0;

      // asynchronous reset mid-cycle with slots populated
      set_d(5'd10, 1'b1, 2'd2); step();
      set_d(5'd11, 1'b1, 2'd1); step();
      chk_slots("prerst", 11,1,1, 10,1,1, 0,0,0);
      #3 rst_n = 1'b0;
      #1;
      chk_slots("arst", 0,0,0, 0,0,0, 0,0,0);
      chk_cnt("arst.cnt", 0);
      step();
      chk_slots("arst_hold", 0,0,0, 0,0,0, 0,0,0);
      @(negedge clk);
      rst_n = 1'b1;
      set_d(5'd12, 1'b1, 2'd1); step();
      chk_slots("postrst", 12,1,1, 0,0,0, 0,0,0);

`ifdef STAGE_INFO_STATS_EN
      // 20 stall edges saturate a 4-bit counter at 15
      set_d(5'd0, 1'b0, 2'd0);
      Stall = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk_cnt("sat.cnt", 15);
      Stall = 1'b0;
      step();
      chk_cnt("sat.hold", 15);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
